// File: rtl/commit_pkg.sv
// Shared types for the commit reorder buffer: entry payload layout and depth helpers.
package commit_pkg;
    localparam int unsigned SEQ_NUM_BITS   = 5;
    localparam int unsigned PHYS_ADDR_BITS = 6;
    localparam int unsigned ROB_DEPTH      = 1 << SEQ_NUM_BITS;

    // Payload held per slot; the sequence number is implied by the slot index.
    typedef struct packed {
        logic [31:0]               pc;
        logic [4:0]                waddr;
        logic [31:0]               wdata;
        logic                      wen;
        logic [PHYS_ADDR_BITS-1:0] preg;
        logic [PHYS_ADDR_BITS-1:0] ppreg;
    } rob_entry_t;

    function automatic int unsigned rob_depth(input int unsigned seq_bits);
        return 1 << seq_bits;
    endfunction
endpackage

// File: rtl/X__WIntf.sv
// Execute-to-writeback completion handshake; W_intf is the consumer side, X_intf the producer.
interface X__WIntf #(
    parameter int unsigned p_seq_num_bits   = 5,
    parameter int unsigned p_phys_addr_bits = 6
);
    logic [31:0]                 pc;
    logic [4:0]                  waddr;
    logic [31:0]                 wdata;
    logic                        wen;
    logic [p_seq_num_bits-1:0]   seq_num;
    logic [p_phys_addr_bits-1:0] preg;
    logic [p_phys_addr_bits-1:0] ppreg;
    logic                        val;
    logic                        rdy;

    modport W_intf (input pc, waddr, wdata, wen, seq_num, preg, ppreg, val, output rdy);
    modport X_intf (output pc, waddr, wdata, wen, seq_num, preg, ppreg, val, input rdy);
endinterface

// File: rtl/commit_rob_storage.sv
// Slot storage for the reorder buffer: flop array of entries with one write port,
// one combinational read port and a per-slot valid vector (write sets, clear clears).
module commit_rob_storage
    import commit_pkg::*;
#(
    parameter int unsigned p_seq_num_bits = SEQ_NUM_BITS
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_wr_en,
    input  logic [p_seq_num_bits-1:0]         i_wr_idx,
    input  rob_entry_t                        i_wr_data,
    input  logic                              i_clr_en,
    input  logic [p_seq_num_bits-1:0]         i_clr_idx,
    input  logic [p_seq_num_bits-1:0]         i_rd_idx,
    output rob_entry_t                        o_rd_data,
    output logic [(1 << p_seq_num_bits)-1:0]  o_valid
);
    localparam int unsigned DEPTH = rob_depth(p_seq_num_bits);

    rob_entry_t       r_entry [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] w_set_mask;
    logic [DEPTH-1:0] w_clr_mask;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dec
            assign w_set_mask[gi] = i_wr_en  & (i_wr_idx  == p_seq_num_bits'(gi));
            assign w_clr_mask[gi] = i_clr_en & (i_clr_idx == p_seq_num_bits'(gi));
        end
    endgenerate

    // Payload is deliberately left unreset; only the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_entry[i_wr_idx] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            r_valid <= (r_valid & ~w_clr_mask) | w_set_mask;
        end
    end

    assign o_rd_data = r_entry[i_rd_idx];
    assign o_valid   = r_valid;
endmodule

// File: rtl/commit_rob.sv
// In-order commit reorder buffer: accepts completions by sequence number, retires from head.
// Optional same-cycle accept-to-commit bypass is enabled by defining COMMIT_ROB_BYPASS_EN.
module commit_rob
    import commit_pkg::*;
#(
    parameter int unsigned p_seq_num_bits   = SEQ_NUM_BITS,
    parameter int unsigned p_phys_addr_bits = PHYS_ADDR_BITS
) (
    input  logic                        clk,
    input  logic                        rst,
    X__WIntf.W_intf                     in,
    output logic                        commit_val,
    input  logic                        commit_rdy,
    output logic [31:0]                 commit_pc,
    output logic [4:0]                  commit_waddr,
    output logic [31:0]                 commit_wdata,
    output logic                        commit_wen,
    output logic [p_seq_num_bits-1:0]   commit_seq_num,
    output logic [p_phys_addr_bits-1:0] commit_preg,
    output logic [p_phys_addr_bits-1:0] commit_ppreg,
    output logic [p_seq_num_bits:0]     pending
);
    localparam int unsigned DEPTH = rob_depth(p_seq_num_bits);

    logic [p_seq_num_bits-1:0] r_head;
    logic [p_seq_num_bits:0]   r_pending;

    logic [DEPTH-1:0] w_valid;
    rob_entry_t       w_in_entry;
    rob_entry_t       w_rd_entry;
    rob_entry_t       w_commit_entry;
    logic             w_slot_busy;
    logic             w_accept;
    logic             w_head_valid;
    logic             w_bypass;
    logic             w_retire;
    logic             w_store_retire;
    logic             w_wr_en;

    always_comb begin
        w_in_entry       = '0;
        w_in_entry.pc    = in.pc;
        w_in_entry.waddr = in.waddr;
        w_in_entry.wdata = in.wdata;
        w_in_entry.wen   = in.wen;
        w_in_entry.preg  = in.preg;
        w_in_entry.ppreg = in.ppreg;
    end

    // Only an occupied target slot stalls a completion; other slots never block.
    assign w_slot_busy  = w_valid[in.seq_num];
    assign in.rdy       = ~w_slot_busy;
    assign w_accept     = in.val & ~w_slot_busy;
    assign w_head_valid = w_valid[r_head];

`ifdef COMMIT_ROB_BYPASS_EN
    assign w_bypass       = ~w_head_valid & in.val & (in.seq_num == r_head);
    assign w_commit_entry = w_bypass ? w_in_entry : w_rd_entry;
`else
    assign w_bypass       = 1'b0;
    assign w_commit_entry = w_rd_entry;
`endif

    assign commit_val     = w_head_valid | w_bypass;
    assign w_retire       = commit_val & commit_rdy;
    assign w_store_retire = w_head_valid & commit_rdy;
    // A bypassed entry that retires immediately never touches storage.
    assign w_wr_en        = w_accept & ~(w_bypass & commit_rdy);

    commit_rob_storage #(
        .p_seq_num_bits (p_seq_num_bits)
    ) u_storage (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (in.seq_num),
        .i_wr_data (w_in_entry),
        .i_clr_en  (w_store_retire),
        .i_clr_idx (r_head),
        .i_rd_idx  (r_head),
        .o_rd_data (w_rd_entry),
        .o_valid   (w_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head    <= '0;
            r_pending <= '0;
        end else begin
            if (w_retire) begin
                r_head <= r_head + p_seq_num_bits'(1);
            end
            case ({w_wr_en, w_store_retire})
                2'b10:   r_pending <= r_pending + (p_seq_num_bits + 1)'(1);
                2'b01:   r_pending <= r_pending - (p_seq_num_bits + 1)'(1);
                default: r_pending <= r_pending;
            endcase
        end
    end

    assign commit_pc      = w_commit_entry.pc;
    assign commit_waddr   = w_commit_entry.waddr;
    assign commit_wdata   = w_commit_entry.wdata;
    assign commit_wen     = w_commit_entry.wen;
    assign commit_preg    = w_commit_entry.preg;
    assign commit_ppreg   = w_commit_entry.ppreg;
    assign commit_seq_num = r_head;
    assign pending        = r_pending;
endmodule

// File: tb/tb_commit_rob.sv
// Scoreboard bench for commit_rob: completions stage expected commits in program order,
// a negedge monitor pops and compares every retired entry.
module tb_commit_rob;
    localparam int SEQ_BITS = 5;
    localparam int PHYS     = 6;
    localparam int DEPTH    = 32;
`ifdef COMMIT_ROB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [4:0]  seq;
        logic [31:0] pc;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        wen;
        logic [5:0]  preg;
        logic [5:0]  ppreg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_val;
    logic        commit_rdy;
    logic [31:0] commit_pc;
    logic [4:0]  commit_waddr;
    logic [31:0] commit_wdata;
    logic        commit_wen;
    logic [4:0]  commit_seq_num;
    logic [5:0]  commit_preg;
    logic [5:0]  commit_ppreg;
    logic [5:0]  pending;

    exp_t       exp_q[$];
    exp_t       stage[DEPTH];
    bit         stage_v[DEPTH];
    logic [4:0] push_seq;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    X__WIntf #(.p_seq_num_bits(SEQ_BITS), .p_phys_addr_bits(PHYS)) w_if ();

    commit_rob #(
        .p_seq_num_bits   (SEQ_BITS),
        .p_phys_addr_bits (PHYS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in             (w_if),
        .commit_val     (commit_val),
        .commit_rdy     (commit_rdy),
        .commit_pc      (commit_pc),
        .commit_waddr   (commit_waddr),
        .commit_wdata   (commit_wdata),
        .commit_wen     (commit_wen),
        .commit_seq_num (commit_seq_num),
        .commit_preg    (commit_preg),
        .commit_ppreg   (commit_ppreg),
        .pending        (pending)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_start(input logic [4:0] seq, input logic [31:0] pc, input logic [31:0] wdata,
                               input logic [4:0] waddr, input logic wen,
                               input logic [5:0] preg, input logic [5:0] ppreg);
        exp_t e;
        w_if.val     = 1'b1;
        w_if.seq_num = seq;
        w_if.pc      = pc;
        w_if.wdata   = wdata;
        w_if.waddr   = waddr;
        w_if.wen     = wen;
        w_if.preg    = preg;
        w_if.ppreg   = ppreg;
        e = '{seq: seq, pc: pc, waddr: waddr, wdata: wdata, wen: wen, preg: preg, ppreg: ppreg};
        stage[seq]   = e;
        stage_v[seq] = 1'b1;
        while (stage_v[push_seq]) begin
            exp_q.push_back(stage[push_seq]);
            stage_v[push_seq] = 1'b0;
            push_seq = push_seq + 5'd1;
        end
    endtask

    task automatic send_rand(input logic [4:0] seq);
        drive_start(seq, $urandom, $urandom, 5'($urandom), 1'($urandom), 6'($urandom), 6'($urandom));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        w_if.val = 1'b0;
    endtask

    task automatic send_cycle(input logic [4:0] seq);
        send_rand(seq);
        @(negedge clk);
        check_val("in_rdy", w_if.rdy, 1);
        step();
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && commit_val && commit_rdy) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_commit", 32'(commit_seq_num), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check_val("c_seq",   32'(commit_seq_num), 32'(e.seq));
                check_val("c_pc",    commit_pc, e.pc);
                check_val("c_waddr", 32'(commit_waddr), 32'(e.waddr));
                check_val("c_wdata", commit_wdata, e.wdata);
                check_val("c_wen",   32'(commit_wen), 32'(e.wen));
                check_val("c_preg",  32'(commit_preg), 32'(e.preg));
                check_val("c_ppreg", 32'(commit_ppreg), 32'(e.ppreg));
                $display("commit seq=%0d pc=%08h wdata=%08h preg=%0d ppreg=%0d",
                         commit_seq_num, commit_pc, commit_wdata, commit_preg, commit_ppreg);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        commit_rdy = 1'b0;
        w_if.val = 1'b0; w_if.seq_num = '0; w_if.pc = '0; w_if.wdata = '0;
        w_if.waddr = '0; w_if.wen = 1'b0; w_if.preg = '0; w_if.ppreg = '0;
        push_seq = '0;
        for (int i = 0; i < DEPTH; i++) stage_v[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check_val("rst_val", commit_val, 0);
        check_val("rst_pending", pending, 0);
        check_val("rst_rdy0", w_if.rdy, 1);
        w_if.seq_num = 5'd17;
        #1 check_val("rst_rdy17", w_if.rdy, 1);

        // Single in-order completion, seq 0
        @(posedge clk); #1;
        commit_rdy = 1'b1;
        drive_start(5'd0, 32'h100, 32'h11, 5'd3, 1'b1, 6'd7, 6'd3);
        @(negedge clk);
        check_val("t1_rdy", w_if.rdy, 1);
        check_val("t1_val_same", commit_val, BYP);
        check_val("t1_pend_same", pending, 0);
        step();
        @(negedge clk);
        check_val("t1_val_next", commit_val, !BYP);
        check_val("t1_pend_next", pending, 32'(!BYP));
        step();
        @(negedge clk);
        check_val("t1_val_done", commit_val, 0);
        check_val("t1_pend_done", pending, 0);

        // Out-of-order completions 3,2,1 with head at 1
        @(posedge clk); #1;
        send_rand(5'd3);
        @(negedge clk); check_val("t2_early_a", commit_val, 0);
        step();
        send_rand(5'd2);
        @(negedge clk); check_val("t2_early_b", commit_val, 0);
        step();
        send_rand(5'd1);
        @(negedge clk); check_val("t2_head_cyc", commit_val, BYP);
        step();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_val("t2_val", commit_val, 1);
            check_val("t2_seq", commit_seq_num, 32'(1 + k + int'(BYP)));
            @(posedge clk); #1;
        end
        @(negedge clk); check_val("t2_val_last", commit_val, !BYP);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("t2_val_done", commit_val, 0);
        check_val("t2_pend_done", pending, 0);

        // Backpressure: four entries 4..7 held for five cycles
        @(posedge clk); #1;
        commit_rdy = 1'b0;
        for (int i = 4; i < 8; i++) send_cycle(5'(i));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val("t3_hold_val", commit_val, 1);
            check_val("t3_hold_seq", commit_seq_num, 4);
            check_val("t3_hold_wdata", commit_wdata, exp_q[0].wdata);
            check_val("t3_hold_pend", pending, 4);
            @(posedge clk); #1;
        end
        commit_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_val("t3_rel_val", commit_val, 1);
            check_val("t3_rel_seq", commit_seq_num, 32'(4 + k));
            @(posedge clk); #1;
        end
        @(negedge clk);
        check_val("t3_val_done", commit_val, 0);
        check_val("t3_pend_done", pending, 0);

        // Fill every slot from head 8, then drain across the wrap
        @(posedge clk); #1;
        commit_rdy = 1'b0;
        for (int i = 0; i < DEPTH; i++) send_cycle(5'(8 + i));
        @(negedge clk);
        check_val("t4_pend_full", pending, 32);
        w_if.seq_num = 5'd8;
        #1 check_val("t4_full_rdy8", w_if.rdy, 0);
        w_if.seq_num = 5'd20;
        #1 check_val("t4_full_rdy20", w_if.rdy, 0);
        @(posedge clk); #1;
        commit_rdy = 1'b1;
        repeat (DEPTH) @(posedge clk);
        #1;
        @(negedge clk);
        check_val("t4_pend_drain", pending, 0);
        check_val("t4_val_drain", commit_val, 0);

        // Stream 8..31 so head wraps to 0, then complete seq 0
        @(posedge clk); #1;
        for (int i = 8; i < DEPTH; i++) send_cycle(5'(i));
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("t4_wrap_head", commit_seq_num, 0);
        check_val("t4_wrap_pend", pending, 0);
        @(posedge clk); #1;
        send_rand(5'd0);
        @(negedge clk);
        check_val("t4_new0_val", commit_val, BYP);
        step();
        @(negedge clk);
        check_val("t4_new0_next", commit_val, !BYP);
        @(posedge clk); #1;

        // Occupied slot stalls its completion, a free slot does not
        commit_rdy = 1'b0;
        for (int i = 1; i < 6; i++) send_cycle(5'(i));
        w_if.val = 1'b1; w_if.seq_num = 5'd5; w_if.wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check_val("t5_busy_rdy", w_if.rdy, 0);
        step();
        send_rand(5'd6);
        @(negedge clk);
        check_val("t5_free_rdy", w_if.rdy, 1);
        step();
        @(negedge clk);
        check_val("t5_pend", pending, 6);

        // Reset mid-stream discards everything
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) stage_v[i] = 1'b0;
        push_seq = '0;
        w_if.seq_num = 5'd5;
        @(negedge clk);
        check_val("t5_rst_val", commit_val, 0);
        check_val("t5_rst_pend", pending, 0);
        check_val("t5_rst_rdy", w_if.rdy, 1);

        // Head-empty completion for seq == head: bypass vs registered path
        @(posedge clk); #1;
        commit_rdy = 1'b1;
        send_rand(5'd0);
        @(negedge clk);
        check_val("t6_val_same", commit_val, BYP);
        check_val("t6_pend_same", pending, 0);
        step();
        @(negedge clk);
        check_val("t6_val_next", commit_val, !BYP);
        check_val("t6_pend_next", pending, 32'(!BYP));
        check_val("t6_head_next", commit_seq_num, 32'(BYP));
        step();
        @(negedge clk);
        check_val("t6_pend_done", pending, 0);
        check_val("drain_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/commit_rob.md
# commit_rob

Reorder buffer that sits directly downstream of the execute-output queues, at the writeback/commit boundary. Accepts completed instructions over the X→W handshake in any order, stores them in a slot indexed by sequence number, and retires them strictly in program (sequence-number) order on a registered commit stream. Decode guarantees that no more than 2^p_seq_num_bits instructions are in flight, so a slot is never reused before it commits.

## Interface
- p_seq_num_bits, 5, sequence-number width; depth = 2^p_seq_num_bits slots
- p_phys_addr_bits, 6, physical register index width
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in  X__WIntf.W_intf  —  completions: pc[31:0], waddr[4:0], wdata[31:0], wen, seq_num, preg, ppreg, val, rdy (rdy driven here)
- commit_val  out  1  head entry valid to retire
- commit_rdy  in  1  consumer accepts head entry
- commit_pc  out  32  retired pc
- commit_waddr  out  5  architectural destination
- commit_wdata  out  32  writeback data
- commit_wen  out  1  architectural write enable
- commit_seq_num  out  p_seq_num_bits  retired sequence number (equals head pointer)
- commit_preg  out  p_phys_addr_bits  newly mapped physical register
- commit_ppreg  out  p_phys_addr_bits  previous mapping; consumer returns it to free list
- pending  out  p_seq_num_bits+1  count of occupied slots

## Operation
- State: per-slot valid bit + payload (all fields except seq_num); head pointer (p_seq_num_bits, wraps mod depth); pending counter.
- Accept: in.rdy = !valid[in.seq_num] (sampled from current-cycle registers). On in.val & in.rdy, write payload to slot in.seq_num, set its valid at next edge.
- Retire: commit_val = valid[head]; commit_* driven from slot[head], commit_seq_num = head. On commit_val & commit_rdy: clear valid[head], head <= head + 1 (natural wrap from 2^p_seq_num_bits-1 to 0).
- pending: +1 on accept-into-storage, −1 on retire-from-storage, both/neither → unchanged. Range 0..depth.
- No same-cycle slot reuse: a write to the slot being retired this cycle is impossible (rdy low since valid set); write to that seq_num stalls until the following cycle.
- Completions arriving for slots other than head never block; only an occupied target slot deasserts in.rdy.
- Contents of commit_* when commit_val=0 are don't-care (verify must not check them).

## Timing
- Reset (rst high at edge): all valid bits 0, head 0, pending 0; hence commit_val 0, in.rdy 1 for every seq_num. Payload storage not reset. Reset mid-operation discards all stored entries immediately.
- Latency (non-bypass): completion for seq_num == head accepted in cycle N → commit_val high in cycle N+1.
- Out-of-order: entries behind a missing head wait; when head completes, consecutive valid slots retire one per cycle while commit_rdy high.
- commit_rdy low holds head and all commit_* stable (entries are registered).
- Throughput: one accept and one retire per cycle sustained.

## Configuration
- COMMIT_ROB_BYPASS_EN defined: if !valid[head] & in.val & in.seq_num == head, commit_* driven combinationally from in, commit_val = 1; if commit_rdy also high the entry retires same cycle (no write, head+1, pending unchanged); if commit_rdy low it is written normally. Zero-cycle accept-to-commit latency.
- Not defined: no in→commit combinational path; latency as in Timing.

## Structure
- Shared package commit_pkg: rob_entry_t packed struct (pc, waddr, wdata, wen, preg, ppreg) parameterised via p_phys_addr_bits; depth constant derived from p_seq_num_bits.
- One sub-module natural: commit_rob_storage — flop array of rob_entry_t with one write port, one read port, and the valid-bit vector (set/clear ports). Head, counter and handshake logic stay in commit_rob.

## Test plan
- Reset, then seq 0 completes (wdata 0x11, wen 1, preg 7, ppreg 3) with commit_rdy 1 → commit_val next cycle with those values, seq_num 0; pending 1→0.
- Completions in order 2,1,0 on consecutive cycles → commits 0,1,2 on three consecutive cycles after seq 0 lands; none earlier.
- commit_rdy held low 5 cycles with 4 entries valid → commit_* stable, head stays, pending 4; release → four retires back-to-back.
- Fill 32 slots, retire through 31 → head wraps to 0; new completion seq 0 accepted and retires next.
- Slot 5 occupied, in.val with seq 5 → in.rdy 0; seq 6 same time elsewhere → rdy 1; rst asserted mid-stream → next cycle commit_val 0, pending 0, in.rdy 1.
- With COMMIT_ROB_BYPASS_EN, head empty, seq == head, commit_rdy 1 → commit_val same cycle, head+1, pending unchanged; without macro → one-cycle delay.
